// File: rtl/nonce_search_ctrl_pkg.sv
// Shared definitions for the nonce search controller.
//   DEF_NONCE_W   : default nonce width
//   DEF_PTR_W     : default entry index width
//   DEF_MAX_NONCE : default last nonce tried for each entry
//   state_t       : controller FSM states
package nonce_search_ctrl_pkg;

    localparam int          DEF_NONCE_W   = 32;
    localparam int          DEF_PTR_W     = 2;
    localparam logic [31:0] DEF_MAX_NONCE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/nonce_search_ctrl_if.sv
// Handshake between the nonce search controller and the hash core.
//   hash_start : one-cycle launch pulse (controller -> core)
//   hash_nonce : nonce under test, stable until the next launch (controller -> core)
//   hash_done  : one-cycle result pulse (core -> controller)
//   hash_msb   : top byte of the hash, valid with hash_done (core -> controller)
// Modports: master = controller side, slave = hash core side.
interface nonce_search_ctrl_if
    import nonce_search_ctrl_pkg::*;
#(
    parameter int NONCE_W = DEF_NONCE_W
);
    logic               hash_start;
    logic [NONCE_W-1:0] hash_nonce;
    logic               hash_done;
    logic [7:0]         hash_msb;

    modport master (
        output hash_start,
        output hash_nonce,
        input  hash_done,
        input  hash_msb
    );

    modport slave (
        input  hash_start,
        input  hash_nonce,
        output hash_done,
        output hash_msb
    );
endinterface

// File: rtl/nonce_search_ctrl_nonce_counter.sv
// Nonce counter for the search controller.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear to 0 (wins over i_inc)
//   i_inc      : advance by one; ignored once the count reaches MAX_NONCE
//   o_count    : current nonce
//   o_at_max   : count equals MAX_NONCE (terminal nonce)
module nonce_counter
    import nonce_search_ctrl_pkg::*;
#(
    parameter int                 NONCE_W   = DEF_NONCE_W,
    parameter logic [NONCE_W-1:0] MAX_NONCE = NONCE_W'(DEF_MAX_NONCE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [NONCE_W-1:0] o_count,
    output logic               o_at_max
);

    logic [NONCE_W-1:0] r_count;
    logic               w_at_max;

    assign w_at_max = (r_count == MAX_NONCE);

    // Saturate at the terminal nonce so the search never wraps back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_at_max = w_at_max;

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce search controller. For each entry 0..num_entradas it launches the
// hash core on nonces 0,1,2,... until the top hash byte is below target or
// the terminal nonce misses, then reports the result for that entry.
//   clk, reset_L          : clock, async active-low reset
//   start, abort          : run start pulse / synchronous abort of a busy run
//   num_entradas, target  : run configuration, captured at start
//   hif (master)          : hash core handshake (hash_start/nonce/done/msb)
//   entry_ptr             : entry under search
//   valid                 : one-cycle result pulse for entry_ptr
//   nonce_valido          : winning nonce, or MAX_NONCE when not_found
//   not_found             : no nonce met the target for this entry
//   busy, done            : run in progress / run completed (level)
module nonce_search_ctrl
    import nonce_search_ctrl_pkg::*;
#(
    parameter int                 NONCE_W   = DEF_NONCE_W,
    parameter int                 PTR_W     = DEF_PTR_W,
    parameter logic [NONCE_W-1:0] MAX_NONCE = NONCE_W'(DEF_MAX_NONCE)
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                start,
    input  logic                abort,
    input  logic [PTR_W-1:0]    num_entradas,
    input  logic [7:0]          target,
    nonce_search_ctrl_if.master hif,
    output logic [PTR_W-1:0]    entry_ptr,
    output logic                valid,
    output logic [NONCE_W-1:0]  nonce_valido,
    output logic                not_found,
    output logic                busy,
    output logic                done
);

    state_t             r_state;
    state_t             w_next_state;

    logic [PTR_W-1:0]   r_num;
    logic [7:0]         r_target;
    logic [7:0]         r_msb;
    logic [PTR_W-1:0]   r_ptr;
    logic [NONCE_W-1:0] r_nonce_valido;
    logic               r_not_found;

    logic [NONCE_W-1:0] w_nonce;
    logic               w_at_max;
    logic               w_busy;
    logic               w_hit;

    logic               w_cap_cfg;
    logic               w_cap_msb;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_ptr_clr;
    logic               w_ptr_inc;
    logic               w_latch_hit;
    logic               w_latch_miss;

    nonce_counter #(
        .NONCE_W   (NONCE_W),
        .MAX_NONCE (MAX_NONCE)
    ) u_nonce_counter (
        .clk      (clk),
        .rst_n    (reset_L),
        .i_clr    (w_cnt_clr),
        .i_inc    (w_cnt_inc),
        .o_count  (w_nonce),
        .o_at_max (w_at_max)
    );

    assign w_busy = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                    (r_state == S_CHECK) || (r_state == S_REPORT);

    // Unsigned compare: target of 0 can never hit.
    assign w_hit = (r_msb < r_target);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cap_cfg    = 1'b0;
        w_cap_msb    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_ptr_clr    = 1'b0;
        w_ptr_inc    = 1'b0;
        w_latch_hit  = 1'b0;
        w_latch_miss = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_cap_cfg    = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_ptr_clr    = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (hif.hash_done) begin
                    w_cap_msb    = 1'b1;
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_hit) begin
                    w_latch_hit  = 1'b1;
                    w_next_state = S_REPORT;
                end else if (w_at_max) begin
                    w_latch_miss = 1'b1;
                    w_next_state = S_REPORT;
                end else begin
                    w_cnt_inc    = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_REPORT: begin
                if (r_ptr < r_num) begin
                    w_ptr_inc    = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_next_state = S_ISSUE;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Abort drops the run outright; none of this cycle's updates apply,
        // and any hash_done still in flight lands in IDLE where it is ignored.
        if (abort && w_busy) begin
            w_next_state = S_IDLE;
            w_cap_cfg    = 1'b0;
            w_cap_msb    = 1'b0;
            w_cnt_clr    = 1'b0;
            w_cnt_inc    = 1'b0;
            w_ptr_clr    = 1'b0;
            w_ptr_inc    = 1'b0;
            w_latch_hit  = 1'b0;
            w_latch_miss = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_num          <= '0;
            r_target       <= '0;
            r_msb          <= '0;
            r_ptr          <= '0;
            r_nonce_valido <= '0;
            r_not_found    <= 1'b0;
        end else begin
            if (w_cap_cfg) begin
                r_num    <= num_entradas;
                r_target <= target;
            end
            if (w_cap_msb) begin
                r_msb <= hif.hash_msb;
            end
            if (w_ptr_clr) begin
                r_ptr <= '0;
            end else if (w_ptr_inc) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_latch_hit) begin
                r_nonce_valido <= w_nonce;
                r_not_found    <= 1'b0;
            end else if (w_latch_miss) begin
                r_nonce_valido <= MAX_NONCE;
                r_not_found    <= 1'b1;
            end
        end
    end

    assign hif.hash_start = (r_state == S_ISSUE);
    assign hif.hash_nonce = w_nonce;

    assign entry_ptr    = r_ptr;
    // An abort landing on the report cycle suppresses the pulse as well.
    assign valid        = (r_state == S_REPORT) && !abort;
    assign nonce_valido = r_nonce_valido;
    assign not_found    = r_not_found;
    assign busy         = w_busy;
    assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_nonce_search_ctrl.sv
module tb_nonce_search_ctrl;
    import nonce_search_ctrl_pkg::*;

    localparam int          NW   = 32;
    localparam int          PW   = 2;
    localparam logic [31:0] MAXN = 32'd3;

    typedef struct {
        logic [PW-1:0] e;
        logic [31:0]   n;
        logic          nf;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] num_entradas = '0;
    logic [7:0]    target = '0;
    logic          hash_done_core = 1'b0;
    logic          hash_done_man = 1'b0;
    logic [7:0]    hash_msb_core = '0;
    logic          hold_core = 1'b0;

    logic [PW-1:0] entry_ptr;
    logic          valid;
    logic [NW-1:0] nonce_valido;
    logic          not_found;
    logic          busy;
    logic          done;

    logic [7:0]    tab [0:3][0:3];
    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;

    nonce_search_ctrl_if #(.NONCE_W(NW)) hif();
    assign hif.hash_done = hash_done_core | hash_done_man;
    assign hif.hash_msb  = hash_msb_core;

    nonce_search_ctrl #(
        .NONCE_W   (NW),
        .PTR_W     (PW),
        .MAX_NONCE (MAXN)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .start        (start),
        .abort        (abort),
        .num_entradas (num_entradas),
        .target       (target),
        .hif          (hif),
        .entry_ptr    (entry_ptr),
        .valid        (valid),
        .nonce_valido (nonce_valido),
        .not_found    (not_found),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_tab(input logic [7:0] v);
        for (int e = 0; e < 4; e++)
            for (int n = 0; n < 4; n++)
                tab[e][n] = v;
    endtask

    // Reference: per entry, first nonce whose hash byte is below target,
    // otherwise the terminal nonce flagged not_found.
    task automatic model(input int num, input logic [7:0] tgt);
        exp_t x;
        for (int e = 0; e <= num; e++) begin
            x.e  = PW'(e);
            x.n  = MAXN;
            x.nf = 1'b1;
            for (int n = int'(MAXN); n >= 0; n--)
                if (tab[e][n] < tgt) begin
                    x.n  = 32'(n);
                    x.nf = 1'b0;
                end
            exp_q.push_back(x);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 2000) begin
            tick();
            k++;
        end
        chk({name, "_done"}, {31'd0, done}, 32'd1);
        chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({name, "_results_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic run(input string name, input int num, input logic [7:0] tgt);
        num_entradas = PW'(num);
        target       = tgt;
        model(num, tgt);
        pulse_start();
        chk({name, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        chk({name, "_done_cleared"}, {31'd0, done}, 32'd0);
        wait_done(name);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_hash_start"}, {31'd0, hif.hash_start}, 32'd0);
        chk({name, "_hash_nonce"}, hif.hash_nonce, 32'd0);
        chk({name, "_entry_ptr"}, {30'd0, entry_ptr}, 32'd0);
        chk({name, "_valid"}, {31'd0, valid}, 32'd0);
        chk({name, "_nonce_valido"}, nonce_valido, 32'd0);
        chk({name, "_not_found"}, {31'd0, not_found}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_done"}, {31'd0, done}, 32'd0);
    endtask

    // Hash core model: answers each launch 1..3 cycles later from the table.
    int re, rn, rd;
    initial begin
        forever begin
            @(negedge clk);
            if (hif.hash_start === 1'b1 && !hold_core) begin
                re = int'(entry_ptr);
                rn = int'(hif.hash_nonce);
                rd = int'($urandom_range(1, 3));
                repeat (rd) @(negedge clk);
                hash_msb_core  = (rn >= 0 && rn <= 3) ? tab[re][rn] : 8'hFF;
                hash_done_core = 1'b1;
                @(negedge clk);
                hash_done_core = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    exp_t mx;
    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: ptr=%0d nonce=%0d nf=%0b, no result expected",
                             entry_ptr, nonce_valido, not_found);
                end else begin
                    mx = exp_q.pop_front();
                    if (entry_ptr !== mx.e || nonce_valido !== mx.n || not_found !== mx.nf) begin
                        errors++;
                        $display("FAIL result: got ptr=%0d nonce=%0d nf=%0b, expected ptr=%0d nonce=%0d nf=%0b",
                                 entry_ptr, nonce_valido, not_found, mx.e, mx.n, mx.nf);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_tab(8'hFF);
        tick(2);
        chk_all_zero("reset");
        reset_L = 1'b1;
        tick(3);
        chk_all_zero("post_reset_idle");

        // Hit on the third nonce of a single entry.
        fill_tab(8'hFF);
        tab[0][0] = 8'h80;
        tab[0][1] = 8'h80;
        tab[0][2] = 8'h05;
        run("single_hit", 0, 8'h10);
        chk("single_hit_nonce_held", hif.hash_nonce, 32'd2);

        // Four entries, each hitting at nonce 0.
        fill_tab(8'hFF);
        for (int e = 0; e < 4; e++) tab[e][0] = 8'h00;
        run("four_entries", 3, 8'h10);

        // Target 0 never hits: terminal nonce reported, no wrap.
        for (int e = 0; e < 4; e++)
            for (int n = 0; n < 4; n++)
                tab[e][n] = 8'($urandom_range(0, 255));
        run("not_found", 0, 8'h00);
        chk("not_found_no_wrap", hif.hash_nonce, MAXN);

        // start and config changes while busy do not disturb the run.
        fill_tab(8'hFF);
        tab[1][3] = 8'h01;
        num_entradas = 2'd1;
        target       = 8'h10;
        model(1, 8'h10);
        pulse_start();
        tick(3);
        num_entradas = 2'd3;
        target       = 8'hFF;
        chk("busy_start_state", {31'd0, busy}, 32'd1);
        pulse_start();
        wait_done("busy_start");

        // Abort in WAIT, then a late hash_done.
        hold_core = 1'b1;
        fill_tab(8'h00);
        num_entradas = 2'd0;
        target       = 8'h10;
        pulse_start();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        hash_done_man = 1'b1;
        tick();
        hash_done_man = 1'b0;
        tick(3);
        chk("abort_late_done_busy", {31'd0, busy}, 32'd0);
        chk("abort_late_done_done", {31'd0, done}, 32'd0);
        hold_core = 1'b0;
        run("after_abort", 0, 8'h10);

        // Asynchronous reset mid-run.
        fill_tab(8'hFF);
        num_entradas = 2'd3;
        target       = 8'h10;
        pulse_start();
        tick(5);
        #2 reset_L = 1'b0;
        #1 chk_all_zero("mid_reset");
        tick(2);
        #2 reset_L = 1'b1;
        tick(10);
        chk_all_zero("after_reset_release");

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            for (int e = 0; e < 4; e++)
                for (int n = 0; n < 4; n++)
                    tab[e][n] = 8'($urandom_range(0, 255));
            run("random", int'($urandom_range(0, 3)), 8'($urandom_range(0, 120)));
        end

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
